// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone SRAM arbiter.
//   arb_state_e     arbiter FSM encoding
//   WB_ARB_TO_DATA  read data returned to a master whose access timed out
//   WB_ARB_CNT_WD   width of the stall counter (timeout build only)
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_OWN0    = 2'd1,
    ARB_OWN1    = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_e;

  localparam logic [31:0] WB_ARB_TO_DATA = 32'hDEAD_BEEF;
  localparam int          WB_ARB_CNT_WD  = 8;

endpackage

// File: rtl/wb_arb_rr_pick.sv
// Combinational two-way round-robin pick.
//   req0, req1  : requests from master 0 / master 1
//   last_owner  : master granted most recently (0 or 1)
//   grant       : chosen master (0 or 1), meaningful only when valid=1
//   valid       : at least one request present
module wb_arb_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic grant,
  output logic valid
);

  assign valid = req0 | req1;
  // On a tie the master that did not own the bus last time wins.
  assign grant = (req0 & req1) ? ~last_owner : req1;

endmodule

// File: rtl/wb_sram_arbiter.sv
// Two-master Wishbone arbiter in front of the single SRAM slave port.
// m0 = management SoC path, m1 = on-chip master (DMA/LA engine).
// Round-robin grant per Wishbone cycle; the owner keeps the slave until it
// drops cyc, then one RELEASE cycle drives the slave bus low.
// Ports:
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   mN_wb_cyc/stb/we/sel/adr/dat_i, mN_wb_dat_o/ack_o   master N (N=0,1)
//   s_wb_cyc/stb/we/sel/adr/dat_o, s_wb_dat_i/ack_i     SRAM slave side
//   s_wb_to_o                 timeout pulse (only with WB_ARB_TIMEOUT_EN)
// Build option WB_ARB_TIMEOUT_EN: stall counter that aborts an access after
// TIMEOUT_CYC unacknowledged strobe cycles.
//
// state       | meaning
// ARB_IDLE    | no owner, sampling requests
// ARB_OWN0    | m0 owns the slave
// ARB_OWN1    | m1 owns the slave
// ARB_RELEASE | slave bus forced low for one cycle before re-arbitration
module wb_sram_arbiter
  import wb_arb_pkg::*;
#(
  parameter int SRAM_ADDR_WD = 9,
  parameter int SRAM_DATA_WD = 32,
  parameter int TIMEOUT_CYC  = 16
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      m0_wb_cyc_i,
  input  logic                      m0_wb_stb_i,
  input  logic                      m0_wb_we_i,
  input  logic [SRAM_DATA_WD/8-1:0] m0_wb_sel_i,
  input  logic [SRAM_ADDR_WD-1:0]   m0_wb_adr_i,
  input  logic [SRAM_DATA_WD-1:0]   m0_wb_dat_i,
  output logic [SRAM_DATA_WD-1:0]   m0_wb_dat_o,
  output logic                      m0_wb_ack_o,
  input  logic                      m1_wb_cyc_i,
  input  logic                      m1_wb_stb_i,
  input  logic                      m1_wb_we_i,
  input  logic [SRAM_DATA_WD/8-1:0] m1_wb_sel_i,
  input  logic [SRAM_ADDR_WD-1:0]   m1_wb_adr_i,
  input  logic [SRAM_DATA_WD-1:0]   m1_wb_dat_i,
  output logic [SRAM_DATA_WD-1:0]   m1_wb_dat_o,
  output logic                      m1_wb_ack_o,
  output logic                      s_wb_cyc_o,
  output logic                      s_wb_stb_o,
  output logic                      s_wb_we_o,
  output logic [SRAM_DATA_WD/8-1:0] s_wb_sel_o,
  output logic [SRAM_ADDR_WD-1:0]   s_wb_adr_o,
  output logic [SRAM_DATA_WD-1:0]   s_wb_dat_o,
  input  logic [SRAM_DATA_WD-1:0]   s_wb_dat_i,
  input  logic                      s_wb_ack_i
`ifdef WB_ARB_TIMEOUT_EN
  ,
  output logic                      s_wb_to_o
`endif
);

  // TIMEOUT_CYC must fit the stall counter range.
  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > (1 << WB_ARB_CNT_WD)) begin : g_bad_timeout
    $error("wb_sram_arbiter: TIMEOUT_CYC out of range");
  end

  arb_state_e state, state_nxt;
  logic       last_owner;
  logic       pick_grant;
  logic       pick_valid;
  logic       grant_take;
  logic       to_hit;

  wb_arb_rr_pick u_pick (
    .req0       (m0_wb_cyc_i & m0_wb_stb_i),
    .req1       (m1_wb_cyc_i & m1_wb_stb_i),
    .last_owner (last_owner),
    .grant      (pick_grant),
    .valid      (pick_valid)
  );

  assign grant_take = (state == ARB_IDLE) && pick_valid;

`ifdef WB_ARB_TIMEOUT_EN
  logic [WB_ARB_CNT_WD-1:0] stall_cnt;
  logic                     own_stb;

  assign own_stb = ((state == ARB_OWN0) && m0_wb_stb_i) ||
                   ((state == ARB_OWN1) && m1_wb_stb_i);
  assign to_hit  = own_stb && !s_wb_ack_i &&
                   (stall_cnt == WB_ARB_CNT_WD'(TIMEOUT_CYC - 1));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || grant_take || s_wb_ack_i) stall_cnt <= '0;
    else if (own_stb)                        stall_cnt <= stall_cnt + WB_ARB_CNT_WD'(1);
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= ARB_IDLE;
      last_owner <= 1'b1;
    end else begin
      state <= state_nxt;
      if (grant_take) last_owner <= pick_grant;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:    if (pick_valid) state_nxt = pick_grant ? ARB_OWN1 : ARB_OWN0;
      ARB_OWN0:    if (!m0_wb_cyc_i || to_hit) state_nxt = ARB_RELEASE;
      ARB_OWN1:    if (!m1_wb_cyc_i || to_hit) state_nxt = ARB_RELEASE;
      ARB_RELEASE: state_nxt = ARB_IDLE;
      default:     state_nxt = ARB_IDLE;
    endcase
  end

  // Outputs are gated during reset so an access aborted by reset never
  // sees its ack, even if the slave answers in the reset cycle.
  always_comb begin
    s_wb_cyc_o  = 1'b0;
    s_wb_stb_o  = 1'b0;
    s_wb_we_o   = 1'b0;
    s_wb_sel_o  = '0;
    s_wb_adr_o  = '0;
    s_wb_dat_o  = '0;
    m0_wb_ack_o = 1'b0;
    m0_wb_dat_o = '0;
    m1_wb_ack_o = 1'b0;
    m1_wb_dat_o = '0;
`ifdef WB_ARB_TIMEOUT_EN
    s_wb_to_o   = 1'b0;
`endif
    if (!wb_rst_i) begin
      case (state)
        ARB_OWN0: begin
          s_wb_cyc_o  = m0_wb_cyc_i;
          s_wb_stb_o  = m0_wb_stb_i;
          s_wb_we_o   = m0_wb_we_i;
          s_wb_sel_o  = m0_wb_sel_i;
          s_wb_adr_o  = m0_wb_adr_i;
          s_wb_dat_o  = m0_wb_dat_i;
          m0_wb_ack_o = s_wb_ack_i | to_hit;
          m0_wb_dat_o = to_hit ? SRAM_DATA_WD'(WB_ARB_TO_DATA) : s_wb_dat_i;
        end
        ARB_OWN1: begin
          s_wb_cyc_o  = m1_wb_cyc_i;
          s_wb_stb_o  = m1_wb_stb_i;
          s_wb_we_o   = m1_wb_we_i;
          s_wb_sel_o  = m1_wb_sel_i;
          s_wb_adr_o  = m1_wb_adr_i;
          s_wb_dat_o  = m1_wb_dat_i;
          m1_wb_ack_o = s_wb_ack_i | to_hit;
          m1_wb_dat_o = to_hit ? SRAM_DATA_WD'(WB_ARB_TO_DATA) : s_wb_dat_i;
        end
        default: ;
      endcase
`ifdef WB_ARB_TIMEOUT_EN
      s_wb_to_o = to_hit;
`endif
    end
  end

endmodule

// File: tb/tb_wb_sram_arbiter.sv
module tb_wb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [3:0]  m0_sel, m1_sel, s_sel;
  logic [8:0]  m0_adr, m1_adr, s_adr;
  logic [31:0] m0_wdat, m1_wdat, m0_rdat, m1_rdat, s_wdat;
  logic        m0_ack, m1_ack, s_cyc, s_stb, s_we;
  logic [31:0] sram_rdat;
  logic        sram_ack;
  logic        sram_en;
  logic        mem_init;
  logic [31:0] mem [0:511];
`ifdef WB_ARB_TIMEOUT_EN
  logic        s_to;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_sram_arbiter #(.SRAM_ADDR_WD(9), .SRAM_DATA_WD(32), .TIMEOUT_CYC(16)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .m0_wb_cyc_i (m0_cyc),
    .m0_wb_stb_i (m0_stb),
    .m0_wb_we_i  (m0_we),
    .m0_wb_sel_i (m0_sel),
    .m0_wb_adr_i (m0_adr),
    .m0_wb_dat_i (m0_wdat),
    .m0_wb_dat_o (m0_rdat),
    .m0_wb_ack_o (m0_ack),
    .m1_wb_cyc_i (m1_cyc),
    .m1_wb_stb_i (m1_stb),
    .m1_wb_we_i  (m1_we),
    .m1_wb_sel_i (m1_sel),
    .m1_wb_adr_i (m1_adr),
    .m1_wb_dat_i (m1_wdat),
    .m1_wb_dat_o (m1_rdat),
    .m1_wb_ack_o (m1_ack),
    .s_wb_cyc_o  (s_cyc),
    .s_wb_stb_o  (s_stb),
    .s_wb_we_o   (s_we),
    .s_wb_sel_o  (s_sel),
    .s_wb_adr_o  (s_adr),
    .s_wb_dat_o  (s_wdat),
    .s_wb_dat_i  (sram_rdat),
    .s_wb_ack_i  (sram_ack)
`ifdef WB_ARB_TIMEOUT_EN
    ,
    .s_wb_to_o   (s_to)
`endif
  );

  // SRAM wrapper model: acks one cycle after a strobe, single beat.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'hC0DE_0000 | i;
    end
    if (rst) begin
      sram_ack <= 1'b0;
    end else begin
      sram_ack <= 1'b0;
      if (sram_en && s_cyc && s_stb && !sram_ack) begin
        sram_ack <= 1'b1;
        if (s_we) begin
          for (int b = 0; b < 4; b++)
            if (s_sel[b]) mem[s_adr][b*8 +: 8] <= s_wdat[b*8 +: 8];
        end else begin
          sram_rdat <= mem[s_adr];
        end
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic m0_req(input logic we, input logic [8:0] adr, input logic [31:0] dat);
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = we; m0_adr = adr; m0_wdat = dat; m0_sel = 4'hF;
  endtask

  task automatic m1_req(input logic we, input logic [8:0] adr, input logic [31:0] dat);
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = we; m1_adr = adr; m1_wdat = dat; m1_sel = 4'hF;
  endtask

  task automatic m0_drop();
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
  endtask

  task automatic m1_drop();
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    check_val("rst_s_cyc", {31'd0, s_cyc}, 32'd0);
    check_val("rst_m0_ack", {31'd0, m0_ack}, 32'd0);
    check_val("rst_m0_dat", m0_rdat, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; sram_en = 1'b1; mem_init = 1'b1;
    m0_drop(); m1_drop();
    m0_sel = '0; m1_sel = '0; m0_adr = '0; m1_adr = '0; m0_wdat = '0; m1_wdat = '0;
    tick();
    mem_init = 1'b0;
    do_reset();
    tick();
    check_val("idle_s_stb", {31'd0, s_stb}, 32'd0);
    check_val("idle_m1_dat", m1_rdat, 32'd0);

    // 1: m0 alone writes then reads back
    m0_req(1'b1, 9'h010, 32'hA5A5_0001);
    #1 check_val("t1_no_same_cyc_grant", {31'd0, s_cyc}, 32'd0);
    tick();
    check_val("t1_s_cyc", {31'd0, s_cyc}, 32'd1);
    check_val("t1_s_we", {31'd0, s_we}, 32'd1);
    check_val("t1_s_adr", {23'd0, s_adr}, 32'h010);
    check_val("t1_s_dat", s_wdat, 32'hA5A5_0001);
    tick();
    check_val("t1_wr_ack", {31'd0, m0_ack}, 32'd1);
    m0_we = 1'b0;
    tick();
    check_val("t1_ack_gap", {31'd0, m0_ack}, 32'd0);
    tick();
    check_val("t1_rd_ack", {31'd0, m0_ack}, 32'd1);
    check_val("t1_rd_dat", m0_rdat, 32'hA5A5_0001);
    check_val("t1_m1_ack", {31'd0, m1_ack}, 32'd0);
    m0_drop();
    tick();
    check_val("t1_release", {31'd0, s_cyc}, 32'd0);
    tick();

    // 2: tie after reset, m0 first, then m1 wins the next tie
    do_reset();
    m0_req(1'b0, 9'h010, 32'd0);
    m1_req(1'b0, 9'h001, 32'd0);
    tick();
    check_val("t2_first_adr", {23'd0, s_adr}, 32'h010);
    tick();
    check_val("t2_m0_ack", {31'd0, m0_ack}, 32'd1);
    check_val("t2_m0_dat", m0_rdat, 32'hA5A5_0001);
    check_val("t2_m1_stall", {31'd0, m1_ack}, 32'd0);
    m0_drop();
    tick();
    check_val("t2_release", {31'd0, s_cyc}, 32'd0);
    m0_req(1'b0, 9'h002, 32'd0);
    tick();
    check_val("t2_idle", {31'd0, s_cyc}, 32'd0);
    tick();
    check_val("t2_tie_m1_cyc", {31'd0, s_cyc}, 32'd1);
    check_val("t2_tie_m1_adr", {23'd0, s_adr}, 32'h001);
    tick();
    check_val("t2_m1_ack", {31'd0, m1_ack}, 32'd1);
    check_val("t2_m1_dat", m1_rdat, 32'hC0DE_0001);
    check_val("t2_m0_no_ack", {31'd0, m0_ack}, 32'd0);
    m1_drop();
    tick();
    tick();
    check_val("t2_gap", {31'd0, s_cyc}, 32'd0);
    tick();
    check_val("t2_m0_adr", {23'd0, s_adr}, 32'h002);
    tick();
    check_val("t2_m0_dat2", m0_rdat, 32'hC0DE_0002);
    m0_drop();
    tick();
    tick();

    // 3: m1 burst of four reads while m0 waits
    m1_req(1'b0, 9'h000, 32'd0);
    m0_req(1'b0, 9'h003, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("t3_m1_adr", {23'd0, s_adr}, i);
      check_val("t3_m0_stall_a", {31'd0, m0_ack}, 32'd0);
      tick();
      check_val("t3_m1_ack", {31'd0, m1_ack}, 32'd1);
      check_val("t3_m1_dat", m1_rdat, 32'hC0DE_0000 | i);
      check_val("t3_m0_stall_b", {31'd0, m0_ack}, 32'd0);
      if (i < 3) m1_adr = 9'(i + 1);
      else m1_drop();
    end
    tick();
    check_val("t3_release_ack", {31'd0, m0_ack}, 32'd0);
    tick();
    check_val("t3_idle_cyc", {31'd0, s_cyc}, 32'd0);
    tick();
    check_val("t3_m0_adr", {23'd0, s_adr}, 32'h003);
    tick();
    check_val("t3_m0_dat", m0_rdat, 32'hC0DE_0003);
    m0_drop();
    tick();
    tick();

    // 4: reset while OWN0 waits for ack; 6: owner drops cyc with ack pending m1
    m0_req(1'b1, 9'h020, 32'h0000_1234);
    tick();
    check_val("t4_own0", {31'd0, s_cyc}, 32'd1);
    rst = 1'b1;
    #1 check_val("t4_rst_ack", {31'd0, m0_ack}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check_val("t4_post_cyc", {31'd0, s_cyc}, 32'd0);
    check_val("t4_post_stb", {31'd0, s_stb}, 32'd0);
    check_val("t4_post_ack", {31'd0, m0_ack}, 32'd0);
    m1_req(1'b0, 9'h001, 32'd0);
    tick();
    check_val("t4_tie_m0_adr", {23'd0, s_adr}, 32'h020);
    check_val("t4_tie_m0_dat", s_wdat, 32'h0000_1234);
    tick();
    check_val("t6_ack", {31'd0, m0_ack}, 32'd1);
    m0_drop();
    #1;
    check_val("t6_ack_fwd", {31'd0, m0_ack}, 32'd1);
    check_val("t6_cyc_low", {31'd0, s_cyc}, 32'd0);
    tick();
    check_val("t6_release", {31'd0, s_cyc}, 32'd0);
    tick();
    check_val("t6_idle", {31'd0, s_cyc}, 32'd0);
    tick();
    check_val("t6_m1_grant", {31'd0, s_cyc}, 32'd1);
    check_val("t6_m1_adr", {23'd0, s_adr}, 32'h001);
    tick();
    check_val("t6_m1_dat", m1_rdat, 32'hC0DE_0001);
    m1_drop();
    tick();
    tick();

`ifdef WB_ARB_TIMEOUT_EN
    // 5: stalled slave, timeout after 16 cycles
    sram_en = 1'b0;
    m0_req(1'b0, 9'h005, 32'd0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k < 16) begin
        check_val("t5_no_ack", {31'd0, m0_ack}, 32'd0);
        check_val("t5_no_to", {31'd0, s_to}, 32'd0);
      end else begin
        check_val("t5_to_ack", {31'd0, m0_ack}, 32'd1);
        check_val("t5_to_dat", m0_rdat, 32'hDEAD_BEEF);
        check_val("t5_to_pulse", {31'd0, s_to}, 32'd1);
      end
    end
    m0_drop();
    tick();
    check_val("t5_released", {31'd0, s_cyc}, 32'd0);
    check_val("t5_to_once", {31'd0, s_to}, 32'd0);
    sram_en = 1'b1;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
